// File: rtl/ireg_border_skew_pkg.sv
// Shared helpers for the multi-row border input register: lane delay
// computation, sign/magnitude conversion and the lane payload type.
package ireg_border_pkg;

  localparam int unsigned IREG_WIDTH_DEF = 8;
  localparam int unsigned IREG_CALC_W    = 64;

  typedef struct packed {
    logic                      valid;
    logic [IREG_WIDTH_DEF-1:0] data;
  } ireg_payload_t;

  function automatic int unsigned lane_delay(input int unsigned r, input int unsigned skew);
    return 1 + r * skew;
  endfunction

  // value must arrive sign-extended to IREG_CALC_W; result holds width-1 magnitude bits.
  // Negating the most-negative code leaves bit width-1 set, which is the saturation trigger.
  function automatic logic [IREG_CALC_W-1:0] sm_abs(input logic [IREG_CALC_W-1:0] value,
                                                    input int unsigned            width,
                                                    input logic                   sat_min);
    logic [IREG_CALC_W-1:0] msb;
    logic [IREG_CALC_W-1:0] mask;
    logic [IREG_CALC_W-1:0] mag;
    msb  = 64'd1 << (width - 1);
    mask = msb - 64'd1;
    mag  = (|(value & msb)) ? (~value + 64'd1) : value;
    if (sat_min && (|(mag & msb))) begin
      return mask;
    end
    return mag & mask;
  endfunction

endpackage

// File: rtl/ireg_border_lane.sv
// One lane of the border register: DEPTH-stage delay line of {valid, data}
// with shared enable/clear, followed by sign/magnitude conversion.
module ireg_border_lane
  import ireg_border_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 1,
  parameter bit          SAT_MIN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic             o_data_sign,
  output logic [WIDTH-2:0] o_data_abs
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } lane_payload_t;

  lane_payload_t                   r_stage [DEPTH];
  lane_payload_t                   w_last;
  logic signed [WIDTH-1:0]         w_sdata;
  logic [IREG_CALC_W-1:0]          w_ext;
  logic [IREG_CALC_W-WIDTH:0]      w_abs_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_stage[k] <= '0;
      end
    end else if (clr) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_stage[k] <= '0;
      end
    end else if (en) begin
      r_stage[0] <= '{valid: i_valid, data: i_data};
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign w_last  = r_stage[DEPTH-1];
  assign w_sdata = w_last.data;
  assign w_ext   = IREG_CALC_W'(w_sdata);

  assign o_valid     = w_last.valid;
  assign o_data_sign = w_last.data[WIDTH-1];
  assign {w_abs_unused, o_data_abs} = sm_abs(w_ext, WIDTH, SAT_MIN);

endmodule

// File: rtl/ireg_border_skew.sv
// Multi-row border input register: lane r delays its operand by 1+r*SKEW
// enabled cycles so the wavefront enters the array diagonally.
module ireg_border_skew
  import ireg_border_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ROWS    = 4,
  parameter int unsigned SKEW    = 1,
  parameter bit          SAT_MIN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic [ROWS-1:0]           i_valid,
  input  logic [ROWS*WIDTH-1:0]     i_data,
  output logic [ROWS-1:0]           o_valid,
  output logic [ROWS-1:0]           o_data_sign,
  output logic [ROWS*(WIDTH-1)-1:0] o_data_abs
);

  for (genvar g = 0; g < ROWS; g++) begin : g_lane
    ireg_border_lane #(
      .WIDTH  (WIDTH),
      .DEPTH  (lane_delay(g, SKEW)),
      .SAT_MIN(SAT_MIN)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .clr        (clr),
      .i_valid    (i_valid[g]),
      .i_data     (i_data[g*WIDTH +: WIDTH]),
      .o_valid    (o_valid[g]),
      .o_data_sign(o_data_sign[g]),
      .o_data_abs (o_data_abs[g*(WIDTH-1) +: WIDTH-1])
    );
  end

endmodule

// File: tb/tb_ireg_border_skew.sv
// Directed bench: skewed timing, saturation modes, stall, clear, async reset, SKEW=0.
module tb_ireg_border_skew;

  logic        clk = 1'b0;
  logic        rst_n, en, clr;

  logic [3:0]  i_valid;
  logic [31:0] i_data;
  logic [3:0]  o_valid, o_sign;
  logic [27:0] o_abs;

  logic        l_iv;
  logic [7:0]  l_id;
  logic        l_ov, l_os;
  logic [6:0]  l_oa;

  logic [1:0]  n_iv;
  logic [15:0] n_id;
  logic [1:0]  n_ov, n_os;
  logic [13:0] n_oa;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  always #5 clk = ~clk;

  ireg_border_skew #(.WIDTH(8), .ROWS(4), .SKEW(1), .SAT_MIN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .o_data_sign(o_sign), .o_data_abs(o_abs)
  );

  ireg_border_skew #(.WIDTH(8), .ROWS(1), .SKEW(1), .SAT_MIN(1'b0)) u_legacy (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .i_valid(l_iv), .i_data(l_id),
    .o_valid(l_ov), .o_data_sign(l_os), .o_data_abs(l_oa)
  );

  ireg_border_skew #(.WIDTH(8), .ROWS(2), .SKEW(0), .SAT_MIN(1'b1)) u_noskew (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .i_valid(n_iv), .i_data(n_id),
    .o_valid(n_ov), .o_data_sign(n_os), .o_data_abs(n_oa)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] lane_abs(input int unsigned r);
    return o_abs[r*7 +: 7];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0;
    i_valid = '0; i_data = '0;
    l_iv = 1'b0; l_id = '0;
    n_iv = '0; n_id = '0;
    #2;
    chk("reset_valid", 32'(o_valid), 32'h0);
    chk("reset_sign",  32'(o_sign),  32'h0);
    chk("reset_abs",   32'(o_abs),   32'h0);
    chk("reset_noskew", 32'({n_ov, n_os, n_oa}), 32'h0);
    #10;
    rst_n = 1'b1;

    // 1: skew timing, lanes {5,-3,7,-1}
    en = 1'b1;
    i_valid = 4'hF;
    i_data  = {8'hFF, 8'h07, 8'hFD, 8'h05};
    tick();
    i_valid = '0; i_data = '0;
    chk("skew_e1_valid", 32'(o_valid), 32'h1);
    chk("skew_e1_abs0",  32'(lane_abs(0)), 32'd5);
    chk("skew_e1_sign0", 32'(o_sign[0]), 32'd0);
    tick();
    chk("skew_e2_valid", 32'(o_valid), 32'h2);
    chk("skew_e2_abs1",  32'(lane_abs(1)), 32'd3);
    chk("skew_e2_sign1", 32'(o_sign[1]), 32'd1);
    tick();
    chk("skew_e3_valid", 32'(o_valid), 32'h4);
    chk("skew_e3_abs2",  32'(lane_abs(2)), 32'd7);
    chk("skew_e3_sign2", 32'(o_sign[2]), 32'd0);
    tick();
    chk("skew_e4_valid", 32'(o_valid), 32'h8);
    chk("skew_e4_abs3",  32'(lane_abs(3)), 32'd1);
    chk("skew_e4_sign3", 32'(o_sign[3]), 32'd1);
    tick();
    chk("skew_e5_valid", 32'(o_valid), 32'h0);

    // 2: most-negative code, both saturation modes
    i_valid = 4'h1; i_data = 32'h0000_0080;
    l_iv = 1'b1; l_id = 8'h80;
    tick();
    chk("sat1_neg_sign", 32'(o_sign[0]), 32'd1);
    chk("sat1_neg_abs",  32'(lane_abs(0)), 32'd127);
    chk("sat0_neg",      32'({l_ov, l_os, l_oa}), 32'({1'b1, 1'b1, 7'd0}));
    i_data = 32'h0000_007F; l_id = 8'h7F;
    tick();
    chk("sat1_pos",      32'({o_sign[0], lane_abs(0)}), 32'({1'b0, 7'd127}));
    chk("sat0_pos",      32'({l_os, l_oa}), 32'({1'b0, 7'd127}));
    i_valid = '0; i_data = '0; l_iv = 1'b0; l_id = '0;
    repeat (4) tick();
    chk("flush_valid", 32'(o_valid), 32'h0);

    // 3: stall with 9 on lane 3 and 6 on lane 0 in flight
    i_valid = 4'h8; i_data = 32'h0900_0000;
    tick();
    i_valid = 4'h1; i_data = 32'h0000_0006;
    tick();
    chk("stall_pre_valid", 32'(o_valid), 32'h1);
    chk("stall_pre_abs",   32'(o_abs), 32'h000_0006);
    en = 1'b0;
    i_valid = 4'hF; i_data = 32'h7F7F_7F7F;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold_valid", 32'(o_valid), 32'h1);
      chk("stall_hold_abs",   32'(o_abs), 32'h000_0006);
    end
    en = 1'b1;
    i_valid = '0; i_data = '0;
    tick();
    chk("stall_e3_valid", 32'(o_valid), 32'h0);
    tick();
    chk("stall_e4_valid", 32'(o_valid), 32'h8);
    chk("stall_e4_abs3",  32'(lane_abs(3)), 32'd9);
    chk("stall_e4_sign3", 32'(o_sign[3]), 32'd0);
    tick();

    // 4: clear beats enable and discards in-flight data
    i_valid = 4'hF; i_data = {8'd4, 8'd3, 8'd2, 8'd1};
    tick();
    tick();
    chk("clr_pre_valid", 32'(o_valid), 32'h3);
    clr = 1'b1;
    tick();
    chk("clr_valid", 32'(o_valid), 32'h0);
    chk("clr_abs",   32'(o_abs),   32'h0);
    chk("clr_sign",  32'(o_sign),  32'h0);
    clr = 1'b0;
    i_valid = '0; i_data = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("clr_after", 32'({o_valid, o_abs}), 32'h0);
    end

    // 5: async reset while every lane holds -5
    i_valid = 4'hF; i_data = 32'hFBFB_FBFB;
    repeat (4) tick();
    chk("ar_pre_valid", 32'(o_valid), 32'hF);
    chk("ar_pre_sign",  32'(o_sign),  32'hF);
    chk("ar_pre_abs",   32'(o_abs),   32'({7'd5, 7'd5, 7'd5, 7'd5}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mid", 32'({o_valid, o_sign, o_abs[23:0]}), 32'h0);
    chk("ar_mid_abs_hi", 32'(o_abs[27:24]), 32'h0);
    #1;
    rst_n = 1'b1;
    i_valid = 4'hF; i_data = 32'h0202_0202;
    tick();
    i_valid = '0; i_data = '0;
    chk("ar_e1", 32'({o_valid, lane_abs(0)}), 32'({4'h1, 7'd2}));
    tick();
    chk("ar_e2", 32'({o_valid, lane_abs(1)}), 32'({4'h2, 7'd2}));
    tick();
    chk("ar_e3", 32'({o_valid, lane_abs(2)}), 32'({4'h4, 7'd2}));
    tick();
    chk("ar_e4", 32'({o_valid, lane_abs(3)}), 32'({4'h8, 7'd2}));

    // 6: SKEW=0, two lanes {-64, 64}
    n_iv = 2'b11; n_id = {8'hC0, 8'h40};
    tick();
    n_iv = '0; n_id = '0;
    chk("ns_valid", 32'(n_ov), 32'h3);
    chk("ns_sign",  32'(n_os), 32'h2);
    chk("ns_abs",   32'(n_oa), 32'({7'd64, 7'd64}));
    tick();
    chk("ns_after", 32'(n_ov), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
